mmio_front_end: RTL
===================

# mmio_front_end

Front-end stage between the PSL MMIO port and the AFU descriptor responder. Registers each incoming MMIO request and checks its parity. Problem-state (non-cfg) accesses are served from a local 64-bit register file. Config reads are forwarded to the descriptor responder. Both response paths merge into the single PSL acknowledge with correct odd data parity.

## Interface
Parameters:
- NUM_REGS, default 8: number of read/write problem-state doubleword registers, indices 0..NUM_REGS-1.
- CFG_TIMEOUT, default 64: cycles to wait for a descriptor-responder ack before self-acking.

Ports:
- clock  in  1  single clock for the block.
- reset  in  1  asynchronous, active-high reset.
- mmio_in  in  MMIOInterfaceInput  PSL request: valid, cfg, read, doubleword, address[0:23], address_parity, data[0:63], data_parity.
- mmio_out  out  MMIOInterfaceOutput  PSL response: ack, data[0:63], data_parity.
- cfg_req  out  MMIOInterfaceInput  forwarded config read, to the descriptor responder.
- cfg_rsp  in  MMIOInterfaceOutput  descriptor responder result: ack, data.
- status_in  in  64  read-only status word, mapped at doubleword index NUM_REGS.
- regs_out  out  NUM_REGS*64  flattened register file; reg i occupies bits [i*64 +: 64].
- error  out  3  sticky error flags:
  - [0] address parity error.
  - [1] write-data parity error.
  - [2] protocol error: request while busy, or cfg timeout.

## Operation
- Parity is odd:
  - A field is good when XOR of (field, parity bit) = 1.
  - Output parity is always driven as mmio_out.data_parity = ~^mmio_out.data.
- FSM states and transitions:
  - IDLE → CAPTURE on mmio_in.valid.
  - CAPTURE → RESPOND for local accesses, cfg writes, and any address-parity error.
  - CAPTURE → CFG_WAIT for a good cfg read.
  - CFG_WAIT → RESPOND on cfg_rsp.ack or on timeout.
  - RESPOND → IDLE.
- CAPTURE latches the whole request and evaluates address and data parity.
- Address parity error:
  - Request is still acked.
  - A read returns 64'hFFFF_FFFF_FFFF_FFFF.
  - A write is dropped.
  - error[0] is set.
- Write-data parity error on a write: write dropped, ack still given, error[1] set.
- Local addressing:
  - Doubleword index = address[0:22].
  - For doubleword accesses, address[23] is ignored.
  - Word accesses select the upper half (bits [0:31]) when address[23]=0, the lower half ([32:63]) when address[23]=1.
- Local reads:
  - Index < NUM_REGS returns the register.
  - Index = NUM_REGS returns status_in.
  - Any other index returns 0.
  - A word read returns the selected 32-bit half replicated into both halves of data.
- Local writes:
  - Index < NUM_REGS only.
  - A word write takes the source word from the matching half of mmio_in.data and updates only the selected half.
  - Other indices are acked and dropped.
- Cfg reads:
  - cfg_req is pulsed for exactly one cycle with the captured fields and valid=1.
  - cfg_rsp.data is captured on cfg_rsp.ack.
- Cfg writes are acked locally with no forward; there are no writable descriptor fields.
- Cfg timeout: after CFG_TIMEOUT cycles in CFG_WAIT with no cfg_rsp.ack, respond with all-ones data and set error[2].
- mmio_in.valid in any state other than IDLE: request ignored, error[2] set.
- cfg_rsp.ack outside CFG_WAIT is ignored.
- Error bits clear only on reset.

## Timing
- Reset values:
  - mmio_out.ack = 0, mmio_out.data = 0, mmio_out.data_parity = 1.
  - cfg_req all zero.
  - regs_out = 0, error = 0.
  - FSM in IDLE; timeout counter = 0.
- Reset asserted mid-transaction aborts it with no ack. A later cfg_rsp.ack is ignored.
- Local access: request valid in cycle N → mmio_out.ack = 1 for exactly one cycle in N+2, with data valid in the same cycle.
- Local write: regs_out updates in cycle N+2.
- Cfg read:
  - cfg_req.valid = 1 in N+2.
  - cfg_rsp.ack in cycle M → mmio_out.ack and data in M+1.
- Cfg timeout: mmio_out.ack in N+3+CFG_TIMEOUT.
- mmio_out.data returns to 0 in the cycle after ack deasserts.
- Back-to-back: the next request is accepted the cycle after the ack cycle.

## Test plan
- Local doubleword write of 64'h0123_4567_89AB_CDEF at index 3 with good parity, then read index 3:
  - Ack at N+2 for each.
  - Read data 64'h0123_4567_89AB_CDEF; data_parity = ~^data.
- Word write of 32'hDEAD_BEEF at index 0 with address[23]=1, after reg0 was written to 0:
  - reg0 = 64'h0000_0000_DEAD_BEEF.
  - Word read with address[23]=1 returns 64'hDEAD_BEEF_DEAD_BEEF.
- Cfg read with the responder model acking 5 cycles after cfg_req:
  - cfg_req.valid is a single pulse.
  - mmio_out carries the model's data one cycle after its ack.
  - error = 0.
- Cfg read with no responder ack, CFG_TIMEOUT=64: ack at N+67 with all-ones data; error[2] = 1.
- Address-parity-bad write to index 2 (reg2 already 0):
  - Acked; reg2 stays 0; error[0] = 1.
  - A following read of index 2 returns 0.
- Reset asserted while in CFG_WAIT, then responder ack arrives:
  - No mmio_out.ack.
  - All outputs at reset values.
  - A new request afterwards completes normally.

Source files
------------

// File: rtl/mmio_front_end.sv
// MMIO front end: registers PSL requests, checks odd parity, serves problem-state registers
// locally and forwards config reads to the descriptor responder.

// PSL numbers bits big-endian; here vectors are [N-1:0], so PSL address[23] is address[0].
typedef struct packed {
    logic        valid;
    logic        cfg;
    logic        read;
    logic        doubleword;
    logic [23:0] address;
    logic        address_parity;
    logic [63:0] data;
    logic        data_parity;
} MMIOInterfaceInput;

typedef struct packed {
    logic        ack;
    logic [63:0] data;
    logic        data_parity;
} MMIOInterfaceOutput;

module mmio_front_end #(
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned CFG_TIMEOUT = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  MMIOInterfaceInput      mmio_in,
    output MMIOInterfaceOutput     mmio_out,
    output MMIOInterfaceInput      cfg_req,
    input  MMIOInterfaceOutput     cfg_rsp,
    input  logic [63:0]            status_in,
    output logic [NUM_REGS*64-1:0] regs_out,
    output logic [2:0]             error
);

    localparam int unsigned CntW = $clog2(CFG_TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(CFG_TIMEOUT);
    localparam logic [22:0] StatusIdx = 23'(NUM_REGS);

    typedef enum logic [1:0] {
        StIdle,
        StCapture,
        StCfgWait,
        StRespond
    } state_e;

    state_e                 state_q, state_d;
    MMIOInterfaceInput      req_q, req_d;
    MMIOInterfaceInput      cfg_req_q, cfg_req_d;
    logic                   ack_q, ack_d;
    logic [63:0]            rdata_q, rdata_d;
    logic [NUM_REGS*64-1:0] regs_q, regs_d;
    logic [2:0]             err_q, err_d;
    logic [CntW-1:0]        cnt_q, cnt_d;

    logic        addr_ok;
    logic        data_ok;
    logic [22:0] dw_idx;
    logic        word_lo;
    logic [63:0] sel_dw;
    logic [31:0] sel_word;
    logic [63:0] local_rdata;
    logic        unused_rsp_parity;

    assign unused_rsp_parity = cfg_rsp.data_parity;

    assign addr_ok = ^{req_q.address, req_q.address_parity};
    assign data_ok = ^{req_q.data, req_q.data_parity};
    assign dw_idx  = req_q.address[23:1];
    assign word_lo = req_q.address[0];

    always_comb begin
        sel_dw = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (dw_idx == 23'(i)) begin
                sel_dw = regs_q[i*64 +: 64];
            end
        end
        if (dw_idx == StatusIdx) begin
            sel_dw = status_in;
        end
        sel_word    = word_lo ? sel_dw[31:0] : sel_dw[63:32];
        local_rdata = req_q.doubleword ? sel_dw : {sel_word, sel_word};
    end

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        cfg_req_d = '0;
        ack_d     = 1'b0;
        rdata_d   = '0;
        regs_d    = regs_q;
        err_d     = err_q;
        cnt_d     = '0;

        // Only IDLE accepts requests; anything arriving later is a protocol violation.
        if (mmio_in.valid && state_q != StIdle) begin
            err_d[2] = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (mmio_in.valid) begin
                    req_d   = mmio_in;
                    state_d = StCapture;
                end
            end
            StCapture: begin
                if (!req_q.read && !data_ok) begin
                    err_d[1] = 1'b1;
                end
                if (!addr_ok) begin
                    err_d[0] = 1'b1;
                    ack_d    = 1'b1;
                    rdata_d  = req_q.read ? '1 : '0;
                    state_d  = StRespond;
                end else if (req_q.cfg && req_q.read) begin
                    cfg_req_d       = req_q;
                    cfg_req_d.valid = 1'b1;
                    state_d         = StCfgWait;
                end else begin
                    ack_d   = 1'b1;
                    state_d = StRespond;
                    if (req_q.read) begin
                        rdata_d = local_rdata;
                    end else if (!req_q.cfg && data_ok) begin
                        for (int unsigned i = 0; i < NUM_REGS; i++) begin
                            if (dw_idx == 23'(i)) begin
                                if (req_q.doubleword) begin
                                    regs_d[i*64 +: 64] = req_q.data;
                                end else if (word_lo) begin
                                    regs_d[i*64 +: 32] = req_q.data[31:0];
                                end else begin
                                    regs_d[i*64+32 +: 32] = req_q.data[63:32];
                                end
                            end
                        end
                    end
                end
            end
            StCfgWait: begin
                if (cfg_rsp.ack) begin
                    ack_d   = 1'b1;
                    rdata_d = cfg_rsp.data;
                    state_d = StRespond;
                end else if (cnt_q == CntMax) begin
                    ack_d    = 1'b1;
                    rdata_d  = '1;
                    err_d[2] = 1'b1;
                    state_d  = StRespond;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRespond: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            req_q     <= '0;
            cfg_req_q <= '0;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
            regs_q    <= '0;
            err_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            cfg_req_q <= cfg_req_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            regs_q    <= regs_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign mmio_out.ack         = ack_q;
    assign mmio_out.data        = rdata_q;
    assign mmio_out.data_parity = ~^rdata_q;
    assign cfg_req              = cfg_req_q;
    assign regs_out             = regs_q;
    assign error                = err_q;

endmodule
